// File: rtl/param_combo_lock_pkg.sv
// Shared types and 7-segment glyphs for the combination lock.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package lock_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        OPEN    = 3'd1,
        CLOSED  = 3'd2,
        ERROR   = 3'd3,
        LOCKOUT = 3'd4,
        PROG    = 3'd5
    } lock_state_t;

    localparam int BCD_MAX = 9;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_T     = 7'h07;
    localparam logic [6:0] SEG_G     = 7'h42;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
        case (d)
            4'd0:    bcd_glyph = SEG_0;
            4'd1:    bcd_glyph = SEG_1;
            4'd2:    bcd_glyph = SEG_2;
            4'd3:    bcd_glyph = SEG_3;
            4'd4:    bcd_glyph = SEG_4;
            4'd5:    bcd_glyph = SEG_5;
            4'd6:    bcd_glyph = SEG_6;
            4'd7:    bcd_glyph = SEG_7;
            4'd8:    bcd_glyph = SEG_8;
            4'd9:    bcd_glyph = SEG_9;
            default: bcd_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/param_combo_lock_hex_msg.sv
// Maps lock state and last accepted digit to the six HEX message glyphs.
// Latency: combinational; the parent registers the result. No backpressure.
// Build option: none (PROG message is always decodable).
module lock_hex_msg
    import lock_pkg::*;
(
    input  lock_state_t state,
    input  logic [3:0]  digit,
    input  logic        digit_vld,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    always_comb begin
        hex0 = SEG_BLANK;
        hex1 = SEG_BLANK;
        hex2 = SEG_BLANK;
        hex3 = SEG_BLANK;
        hex4 = SEG_BLANK;
        hex5 = SEG_BLANK;
        case (state)
            ENTRY: begin
                if (digit_vld) hex0 = bcd_glyph(digit);
            end
            OPEN: begin
                hex3 = SEG_O; hex2 = SEG_P; hex1 = SEG_E; hex0 = SEG_N;
            end
            CLOSED: begin
                hex5 = SEG_C; hex4 = SEG_L; hex3 = SEG_O;
                hex2 = SEG_S; hex1 = SEG_E; hex0 = SEG_D;
            end
            ERROR: begin
                hex4 = SEG_E; hex3 = SEG_R; hex2 = SEG_R;
                hex1 = SEG_O; hex0 = SEG_R;
            end
            LOCKOUT: begin
                hex5 = SEG_L; hex4 = SEG_O; hex3 = SEG_C;
                hex2 = SEG_O; hex1 = SEG_U; hex0 = SEG_T;
            end
            PROG: begin
                hex3 = SEG_P; hex2 = SEG_R; hex1 = SEG_O; hex0 = SEG_G;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_combo_lock.sv
// Digit-sequence combination lock with failed-entry lockout and HEX messages.
// Latency: every input event shows on the registered outputs 1 cycle after sampling; no backpressure.
// COMBO_LOCK_PROG_EN builds the PROG state that reloads the code from OPEN.
module param_combo_lock
    import lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 24'h703262,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              clear,
    input  logic                              relock,
    input  logic                              prog,
    output logic                              is_open,
    output logic                              is_closed,
    output logic                              is_error,
    output logic                              locked_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt,
    output logic [6:0]                        hex0,
    output logic [6:0]                        hex1,
    output logic [6:0]                        hex2,
    output logic [6:0]                        hex3,
    output logic [6:0]                        hex4,
    output logic [6:0]                        hex5
);

    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam int IW = $clog2(NUM_DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    lock_state_t        state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [FW-1:0]      fail_q, fail_d;
    logic               miss_q, miss_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [DIGIT_W-1:0] last_q, last_d;
    logic               last_vld_q, last_vld_d;
    logic [DIGIT_W-1:0] code_dig;
    logic               digit_bad;
    logic               last_slot;
    logic [6:0]         hex_d [6];

`ifdef COMBO_LOCK_PROG_EN
    logic [CW-1:0] code_q, code_d, shadow_q, shadow_d;
`else
    logic [CW-1:0] code_q;
    logic          prog_unused;
    assign code_q      = DEFAULT_CODE;
    assign prog_unused = prog;
`endif

    // Digit 0 lives in the most-significant slot of the code word.
    assign code_dig  = code_q[CW-1-int'(idx_q)*DIGIT_W -: DIGIT_W];
    assign digit_bad = int'(digit_in) > BCD_MAX;
    assign last_slot = idx_q == IW'(NUM_DIGITS - 1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fail_d     = fail_q;
        miss_d     = miss_q;
        timer_d    = timer_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
`ifdef COMBO_LOCK_PROG_EN
        code_d     = code_q;
        shadow_d   = shadow_q;
`endif
        case (state_q)
            ENTRY: begin
                if (clear) begin
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    last_vld_d = 1'b0;
                end else if (digit_valid) begin
                    if (digit_bad) begin
                        state_d = ERROR;
                    end else begin
                        last_d     = digit_in;
                        last_vld_d = 1'b1;
                        if (last_slot) begin
                            idx_d  = '0;
                            miss_d = 1'b0;
                            if (!miss_q && digit_in == code_dig) begin
                                state_d = OPEN;
                                fail_d  = '0;
                            end else if (int'(fail_q) + 1 == MAX_TRIES) begin
                                state_d = LOCKOUT;
                                timer_d = TW'(LOCKOUT_CYCLES - 1);
                                fail_d  = fail_q + 1'b1;
                            end else begin
                                state_d = CLOSED;
                                fail_d  = fail_q + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                            if (digit_in != code_dig) miss_d = 1'b1;
                        end
                    end
                end
            end
            OPEN: begin
                if (relock) begin
                    state_d    = ENTRY;
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    last_vld_d = 1'b0;
                end
`ifdef COMBO_LOCK_PROG_EN
                else if (prog) begin
                    state_d = PROG;
                    idx_d   = '0;
                end
`endif
            end
            CLOSED, ERROR: begin
                if (clear) begin
                    state_d    = ENTRY;
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    last_vld_d = 1'b0;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ENTRY;
                    fail_d     = '0;
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    last_vld_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef COMBO_LOCK_PROG_EN
            PROG: begin
                if (relock || (digit_valid && digit_bad)) begin
                    state_d = OPEN;
                    idx_d   = '0;
                end else if (digit_valid) begin
                    shadow_d[CW-1-int'(idx_q)*DIGIT_W -: DIGIT_W] = digit_in;
                    if (last_slot) begin
                        code_d  = shadow_d;
                        state_d = OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ENTRY;
        endcase
    end

    lock_hex_msg u_hex_msg (
        .state     (state_d),
        .digit     (4'(last_d)),
        .digit_vld (last_vld_d),
        .hex0      (hex_d[0]),
        .hex1      (hex_d[1]),
        .hex2      (hex_d[2]),
        .hex3      (hex_d[3]),
        .hex4      (hex_d[4]),
        .hex5      (hex_d[5])
    );

    // Status and HEX registers are loaded from next-state values so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTRY;
            idx_q      <= '0;
            fail_q     <= '0;
            miss_q     <= 1'b0;
            timer_q    <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            is_open    <= 1'b0;
            is_closed  <= 1'b0;
            is_error   <= 1'b0;
            locked_out <= 1'b0;
            hex0       <= SEG_BLANK;
            hex1       <= SEG_BLANK;
            hex2       <= SEG_BLANK;
            hex3       <= SEG_BLANK;
            hex4       <= SEG_BLANK;
            hex5       <= SEG_BLANK;
`ifdef COMBO_LOCK_PROG_EN
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fail_q     <= fail_d;
            miss_q     <= miss_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            is_open    <= state_d == OPEN;
            is_closed  <= state_d == CLOSED;
            is_error   <= state_d == ERROR;
            locked_out <= state_d == LOCKOUT;
            hex0       <= hex_d[0];
            hex1       <= hex_d[1];
            hex2       <= hex_d[2];
            hex3       <= hex_d[3];
            hex4       <= hex_d[4];
            hex5       <= hex_d[5];
`ifdef COMBO_LOCK_PROG_EN
            code_q     <= code_d;
            shadow_q   <= shadow_d;
`endif
        end
    end

    assign digit_idx = idx_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_param_combo_lock.sv
// Directed bench for param_combo_lock with a short lockout window.
module tb_param_combo_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear;
    logic       relock;
    logic       prog;
    logic       is_open, is_closed, is_error, locked_out;
    logic [2:0] digit_idx;
    logic [1:0] fail_cnt;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [41:0] MSG_OPEN   = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
    localparam logic [41:0] MSG_CLOSED = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
    localparam logic [41:0] MSG_ERROR  = {7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};
    localparam logic [41:0] MSG_LOCK   = {7'h47, 7'h40, 7'h46, 7'h40, 7'h41, 7'h07};
    localparam logic [41:0] MSG_PROG   = {7'h7F, 7'h7F, 7'h0C, 7'h2F, 7'h40, 7'h42};
    localparam logic [41:0] MSG_BLANK  = {6{7'h7F}};

    param_combo_lock #(.LOCKOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .clear(clear), .relock(relock), .prog(prog),
        .is_open(is_open), .is_closed(is_closed), .is_error(is_error),
        .locked_out(locked_out), .digit_idx(digit_idx), .fail_cnt(fail_cnt),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    wire [41:0] hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};
    wire [3:0]  status  = {is_open, is_closed, is_error, locked_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] d);
        @(negedge clk);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        relock = 1'b1;
        tick();
        relock = 1'b0;
    endtask

    task automatic enter_code(input logic [23:0] c);
        for (int i = 5; i >= 0; i--) strobe(c[i*4 +: 4]);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (status !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", status); end
        n_checks++;
        if (digit_idx !== 3'd0 || fail_cnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_counts: idx %0d fail %0d want 0 0", digit_idx, fail_cnt);
        end
        n_checks++;
        if (hex_all !== MSG_BLANK) begin n_fail++; $display("FAIL reset_hex: got %h want %h", hex_all, MSG_BLANK); end
    endtask

    task automatic test_open();
        do_reset();
        strobe(4'd7);
        n_checks++;
        if (hex0 !== 7'h78 || hex1 !== 7'h7F || digit_idx !== 3'd1) begin
            n_fail++; $display("FAIL entry_hex: hex0 %h hex1 %h idx %0d want 78 7f 1", hex0, hex1, digit_idx);
        end
        strobe(4'd0); strobe(4'd3); strobe(4'd2); strobe(4'd6); strobe(4'd2);
        n_checks++;
        if (status !== 4'b1000 || fail_cnt !== 2'd0 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL open_status: st %b fail %0d idx %0d want 1000 0 0", status, fail_cnt, digit_idx);
        end
        n_checks++;
        if (hex_all !== MSG_OPEN) begin n_fail++; $display("FAIL open_hex: got %h want %h", hex_all, MSG_OPEN); end
        strobe(4'd1);
        pulse_clear();
        n_checks++;
        if (status !== 4'b1000) begin n_fail++; $display("FAIL open_ignores: st %b want 1000", status); end
        pulse_relock();
        n_checks++;
        if (status !== 4'b0000 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL relock: st %b idx %0d want 0000 0", status, digit_idx);
        end
    endtask

    task automatic test_closed();
        do_reset();
        strobe(4'd7); strobe(4'd1); strobe(4'd3); strobe(4'd2); strobe(4'd6);
        n_checks++;
        if (status !== 4'b0000 || digit_idx !== 3'd5) begin
            n_fail++; $display("FAIL closed_early: st %b idx %0d want 0000 5", status, digit_idx);
        end
        strobe(4'd2);
        n_checks++;
        if (status !== 4'b0100 || fail_cnt !== 2'd1 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL closed_status: st %b fail %0d idx %0d want 0100 1 0", status, fail_cnt, digit_idx);
        end
        n_checks++;
        if (hex_all !== MSG_CLOSED) begin n_fail++; $display("FAIL closed_hex: got %h want %h", hex_all, MSG_CLOSED); end
        strobe(4'd7);
        n_checks++;
        if (status !== 4'b0100 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL closed_ignores: st %b idx %0d want 0100 0", status, digit_idx);
        end
        pulse_clear();
        n_checks++;
        if (status !== 4'b0000 || digit_idx !== 3'd0 || fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL closed_clear: st %b idx %0d fail %0d want 0000 0 1", status, digit_idx, fail_cnt);
        end
    endtask

    task automatic test_lockout();
        int cnt;
        do_reset();
        enter_code(24'h713262); pulse_clear();
        enter_code(24'h700000); pulse_clear();
        n_checks++;
        if (fail_cnt !== 2'd2) begin n_fail++; $display("FAIL lock_pre: fail %0d want 2", fail_cnt); end
        enter_code(24'h123456);
        n_checks++;
        if (status !== 4'b0001 || hex_all !== MSG_LOCK) begin
            n_fail++; $display("FAIL lock_enter: st %b hex %h want 0001 %h", status, hex_all, MSG_LOCK);
        end
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            digit_in    = 4'd7;
            digit_valid = 1'b1;
            clear       = 1'b1;
            tick();
            if (!locked_out) break;
            cnt++;
        end
        digit_valid = 1'b0;
        clear       = 1'b0;
        n_checks++;
        if (cnt !== 8) begin n_fail++; $display("FAIL lock_len: got %0d cycles want 8", cnt); end
        n_checks++;
        if (status !== 4'b0000 || fail_cnt !== 2'd0 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL lock_exit: st %b fail %0d idx %0d want 0000 0 0", status, fail_cnt, digit_idx);
        end
        enter_code(24'h703262);
        n_checks++;
        if (is_open !== 1'b1) begin n_fail++; $display("FAIL lock_reopen: open %b want 1", is_open); end
    endtask

    task automatic test_error();
        do_reset();
        enter_code(24'h111111); pulse_clear();
        strobe(4'd7); strobe(4'd0); strobe(4'd10);
        n_checks++;
        if (status !== 4'b0010 || digit_idx !== 3'd2 || fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL error_status: st %b idx %0d fail %0d want 0010 2 1", status, digit_idx, fail_cnt);
        end
        n_checks++;
        if (hex_all !== MSG_ERROR) begin n_fail++; $display("FAIL error_hex: got %h want %h", hex_all, MSG_ERROR); end
        pulse_clear();
        strobe(4'd7);
        @(negedge clk);
        digit_in = 4'd0; digit_valid = 1'b1; clear = 1'b1;
        tick();
        digit_valid = 1'b0; clear = 1'b0;
        n_checks++;
        if (status !== 4'b0000 || digit_idx !== 3'd0 || hex_all !== MSG_BLANK) begin
            n_fail++; $display("FAIL clear_wins: st %b idx %0d hex %h want 0000 0 %h", status, digit_idx, hex_all, MSG_BLANK);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        strobe(4'd7); strobe(4'd0); strobe(4'd3);
        do_reset();
        n_checks++;
        if (digit_idx !== 3'd0 || hex_all !== MSG_BLANK) begin
            n_fail++; $display("FAIL mid_reset: idx %0d hex %h want 0 %h", digit_idx, hex_all, MSG_BLANK);
        end
        enter_code(24'h703262);
        n_checks++;
        if (is_open !== 1'b1) begin n_fail++; $display("FAIL mid_reset_open: open %b want 1", is_open); end
    endtask

    task automatic test_prog();
        do_reset();
        enter_code(24'h703262);
        @(negedge clk);
        prog = 1'b1;
        tick();
        prog = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
        n_checks++;
        if (hex_all !== MSG_PROG || status !== 4'b0000 || digit_idx !== 3'd0) begin
            n_fail++; $display("FAIL prog_enter: hex %h st %b idx %0d want %h 0000 0", hex_all, status, digit_idx, MSG_PROG);
        end
        enter_code(24'h123456);
        n_checks++;
        if (is_open !== 1'b1) begin n_fail++; $display("FAIL prog_done: open %b want 1", is_open); end
        pulse_relock();
        enter_code(24'h703262);
        n_checks++;
        if (is_closed !== 1'b1) begin n_fail++; $display("FAIL prog_oldcode: closed %b want 1", is_closed); end
        pulse_clear();
        enter_code(24'h123456);
        n_checks++;
        if (is_open !== 1'b1) begin n_fail++; $display("FAIL prog_newcode: open %b want 1", is_open); end
`else
        n_checks++;
        if (status !== 4'b1000 || hex_all !== MSG_OPEN) begin
            n_fail++; $display("FAIL prog_ignored: st %b hex %h want 1000 %h", status, hex_all, MSG_OPEN);
        end
        enter_code(24'h123456);
        pulse_relock();
        enter_code(24'h123456);
        n_checks++;
        if (is_closed !== 1'b1) begin n_fail++; $display("FAIL prog_nocode: closed %b want 1", is_closed); end
        pulse_clear();
        enter_code(24'h703262);
        n_checks++;
        if (is_open !== 1'b1) begin n_fail++; $display("FAIL prog_default: open %b want 1", is_open); end
`endif
    endtask

    initial begin
        rst = 1'b1; digit_in = '0; digit_valid = 1'b0;
        clear = 1'b0; relock = 1'b0; prog = 1'b0;
        test_reset();
        test_open();
        test_closed();
        test_lockout();
        test_error();
        test_mid_reset();
        test_prog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_combo_lock.md
Name: param_combo_lock

Overview:
- Parametrised digit-sequence combination lock for the DE1-SoC lab designs.
- Accepts strobed decimal digits, compares them against a stored code of NUM_DIGITS digits, and reports OPEN, CLOSED or ERROR.
- Enforces a timed lockout after MAX_TRIES consecutive failed entries.
- Drives six active-low 7-segment message outputs; sits between the switch/key debounce logic and the HEX displays at the top level.

Parameters:
- NUM_DIGITS, 6: number of digits in the code.
- DIGIT_W, 4: bits per digit.
- DEFAULT_CODE, 24'h703262: reset code; digit 0 is in the MS nibble. Width is NUM_DIGITS*DIGIT_W.
- MAX_TRIES, 3: consecutive failures that trigger lockout (minimum 1).
- LOCKOUT_CYCLES, 1000: length of the lockout, in clk cycles (minimum 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- digit_in  in  DIGIT_W  candidate digit.
- digit_valid  in  1  one-cycle strobe; digit_in is sampled this cycle.
- clear  in  1  returns the block from CLOSED or ERROR to ENTRY.
- relock  in  1  returns the block from OPEN to ENTRY.
- prog  in  1  code-programming request (see Optional Feature).
- is_open  out  1  state is OPEN.
- is_closed  out  1  state is CLOSED.
- is_error  out  1  state is ERROR.
- locked_out  out  1  state is LOCKOUT.
- digit_idx  out  $clog2(NUM_DIGITS+1)  count of digits accepted in the current entry.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed entries.
- hex0..hex5  out  7 each  active-low segments {g..a}.

Behaviour:
- Synchronous active-high reset; rst dominates every other input.
- Values on reset:
  - state = ENTRY; code register = DEFAULT_CODE.
  - digit_idx = 0, fail_cnt = 0, miss flag = 0, timer = 0.
  - All status outputs = 0; hex outputs all blank (7'h7F).
- All outputs are registered. Any input event is reflected exactly 1 cycle after the sampling edge.
- ENTRY state, on digit_valid:
  - digit_in > 9: go to ERROR; digit_idx is held; fail_cnt is unchanged.
  - Otherwise: compare digit_in with code digit [digit_idx]. A mismatch sets a sticky miss flag. digit_idx increments.
- ENTRY state, on the last digit (digit_idx == NUM_DIGITS-1 with digit_valid):
  - No miss and the last digit matches: go to OPEN; fail_cnt = 0.
  - Otherwise, if fail_cnt+1 == MAX_TRIES: go to LOCKOUT; timer = LOCKOUT_CYCLES-1.
  - Otherwise: go to CLOSED; fail_cnt increments.
- Early mismatches do not reveal anything: the entry always runs to NUM_DIGITS digits.
- OPEN:
  - digit_valid and clear are ignored.
  - relock: go to ENTRY; digit_idx and miss flag cleared.
- CLOSED / ERROR:
  - digit_valid is ignored.
  - clear: go to ENTRY; digit_idx and miss flag cleared; fail_cnt is kept.
- LOCKOUT:
  - All inputs except rst are ignored.
  - The timer decrements each cycle. The cycle the timer reads 0: go to ENTRY with fail_cnt = 0. locked_out is therefore high for exactly LOCKOUT_CYCLES cycles.
- Simultaneous events in ENTRY: clear wins over digit_valid; digit_idx and miss flag are cleared and the digit is discarded.
- The relock and prog inputs are ignored outside OPEN.
- digit_idx never exceeds NUM_DIGITS-1 while in ENTRY. It resets to 0 on each exit to OPEN, CLOSED or LOCKOUT.
- HEX messages (hex5..hex0):
  - ENTRY: last accepted digit on hex0, other displays blank.
  - OPEN: "  OPEn".
  - CLOSED: "CLOSEd".
  - ERROR: " ErrOr".
  - LOCKOUT: "LOCOUt".
  - PROG: "  PrOG".

Optional Feature:
- Macro: COMBO_LOCK_PROG_EN.
- Defined:
  - prog in OPEN enters PROG state, with digit_idx = 0.
  - The next NUM_DIGITS valid digits fill a shadow register.
  - After the last digit, the code register is loaded from the shadow and the state returns to OPEN.
  - A digit > 9 or relock during PROG aborts: the code is unchanged and the state returns to OPEN.
- Undefined:
  - The prog port exists but is ignored; PROG state and shadow register are not built.
  - The code is the constant DEFAULT_CODE.

Decomposition:
- Package lock_pkg:
  - State enum lock_state_t: ENTRY, OPEN, CLOSED, ERROR, LOCKOUT, PROG.
  - BCD_MAX = 9.
  - 7-segment glyph constants: digits 0-9 and letters O P E n C L S d r U t G, plus BLANK.
- Sub-module lock_hex_msg: combinational lock_state_t + last digit -> hex0..hex5. It is instantiated once inside; its outputs are registered in the parent.

Test Plan:
- Reset, then digits 7,0,3,2,6,2 -> is_open=1 one cycle after the 6th strobe; fail_cnt=0; hex = "  OPEn".
- 7,1,3,2,6,2 -> no status change before the 6th strobe; then is_closed=1, fail_cnt=1, hex="CLOSEd"; clear -> ENTRY with digit_idx=0.
- Bench with LOCKOUT_CYCLES=8: three wrong entries separated by clear -> locked_out=1 for exactly 8 cycles; digit strobes during lockout are ignored; afterwards ENTRY with fail_cnt=0.
- digits 7,0,then 10 -> is_error=1, digit_idx stays 2, fail_cnt unchanged; clear together with digit_valid=1 in ENTRY -> digit discarded, digit_idx=0.
- rst asserted after 3 correct digits -> digit_idx=0; the full code 7,0,3,2,6,2 then opens.
- With COMBO_LOCK_PROG_EN: open, prog, enter 1,2,3,4,5,6, relock -> old code gives CLOSED, 1,2,3,4,5,6 gives OPEN. Without the macro: prog has no effect.
